mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. It generalises the ALU's signed/unsigned operand handling to a configurable data width. It adds what a purely combinational ALU lacks: a configurable operation latency, a busy handshake for the hazard unit, and held result state.

---
 rtl/mdu_defs_pkg.sv | 26 ++
 rtl/mdu_compute.sv | 85 ++++++++
 rtl/mul_div_unit.sv | 105 ++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM states and sizing helpers.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic int unsigned mdu_max(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath: signed/unsigned multiply
// and divide producing the next HI/LO pair.
module mdu_compute
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0] uprod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   bm_safe;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mr;
  logic [WIDTH-1:0]   sq;
  logic [WIDTH-1:0]   sr;
  logic               a_neg;
  logic               b_neg;

  assign a_neg = A[WIDTH-1];
  assign b_neg = B[WIDTH-1];

  // Low 2W bits of the sign-extended product are the signed product
  assign sprod = {{WIDTH{a_neg}}, A} * {{WIDTH{b_neg}}, B};
  assign uprod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign div_zero = (B == '0);
  assign b_safe   = div_zero ? ONE : B;

  assign uq = A / b_safe;
  assign ur = A % b_safe;

  assign a_mag   = a_neg ? (~A + ONE) : A;
  assign b_mag   = b_neg ? (~B + ONE) : B;
  assign bm_safe = div_zero ? ONE : b_mag;

  assign mq = a_mag / bm_safe;
  assign mr = a_mag % bm_safe;

  // Truncate toward zero; remainder follows dividend.
  // MIN/-1 wraps back to MIN with zero remainder.
  assign sq = (a_neg ^ b_neg) ? (~mq + ONE) : mq;
  assign sr = a_neg ? (~mr + ONE) : mr;

  always_comb begin
    next_hi = '0;
    next_lo = '0;
    case (mdu_op_e'(op))
      MDU_MULT: begin
        next_hi = sprod[2*WIDTH-1:WIDTH];
        next_lo = sprod[WIDTH-1:0];
      end
      MDU_MULTU: begin
        next_hi = uprod[2*WIDTH-1:WIDTH];
        next_lo = uprod[WIDTH-1:0];
      end
      MDU_DIV: begin
        next_hi = sr;
        next_lo = sq;
      end
      MDU_DIVU: begin
        next_hi = ur;
        next_lo = uq;
      end
      default: begin
        next_hi = A;
        next_lo = A;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO state,
// busy handshake and deferred result commit.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_MAX =
    mdu_max(MUL_CYCLES, DIV_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_1  = CW'(1);

  mdu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic             pend_skip_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;
  logic             c_dz;

  mdu_compute #(
    .WIDTH(WIDTH)
  ) u_compute (
    .op      (op),
    .A       (A),
    .B       (B),
    .next_hi (c_hi),
    .next_lo (c_lo),
    .div_zero(c_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            case (mdu_op_e'(op))
              MDU_MULT, MDU_MULTU: begin
                pend_hi_q   <= c_hi;
                pend_lo_q   <= c_lo;
                pend_skip_q <= 1'b0;
                cnt_q       <= MUL_LD;
                state_q     <= MDU_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                pend_hi_q   <= c_hi;
                pend_lo_q   <= c_lo;
                pend_skip_q <= c_dz;
                cnt_q       <= DIV_LD;
                state_q     <= MDU_RUN;
              end
              MDU_MTHI: hi_q <= A;
              MDU_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          cnt_q <= cnt_q - CNT_1;
          if (cnt_q == CNT_1) begin
            state_q <= MDU_IDLE;
            // Divide by zero burns the cycles but keeps HI/LO
            if (!pend_skip_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy = (state_q == MDU_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at the
// default configuration.
module tb_mul_div_unit;
  import mdu_defs::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec;
  int nerr;
  int n;

  mul_div_unit #(
    .WIDTH     (32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input mdu_op_e     o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    op    = 3'd7;
    A     = '0;
    B     = '0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic run_op(
    input string       tag,
    input mdu_op_e     o,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          ncyc,
    input logic [31:0] ehi,
    input logic [31:0] elo
  );
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          c;
    old_hi = hi;
    old_lo = lo;
    issue(o, a, b);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
    wait_idle(c);
    chk({tag, "_cyc"}, 64'(c), 64'(ncyc));
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd7;
    A     = '0;
    B     = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b0;
    tick();

    issue(MDU_MTHI, 32'h1234, '0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'(0));

    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5,
           32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MDU_DIVU, 32'd7, 32'd2, 10,
           32'd1, 32'd3);
    run_op("divmin", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           10, 32'd0, 32'h8000_0000);

    issue(MDU_MTHI, 32'h11, '0);
    issue(MDU_MTLO, 32'h22, '0);
    chk("preset", {hi, lo}, {32'h11, 32'h22});
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 10,
           32'h11, 32'h22);

    issue(MDU_MULT, 32'd3, 32'd4);
    start = 1'b1;
    op    = MDU_MTHI;
    A     = 32'hDEAD;
    tick();
    op    = MDU_DIVU;
    A     = 32'd100;
    B     = 32'd7;
    tick();
    start = 1'b0;
    op    = 3'd7;
    chk("ign_hold", {hi, lo}, {32'h11, 32'h22});
    wait_idle(n);
    chk("ign_cyc", 64'(n), 64'(3));
    chk("ign_hilo", {hi, lo}, {32'd0, 32'd12});
    tick();
    chk("ign_nodiv", 64'(busy), 64'(0));

    issue(MDU_MTHI, 32'h55, '0);
    issue(MDU_DIV, 32'd100, 32'd7);
    tick();
    tick();
    chk("rstmid_busy0", 64'(busy), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_hilo", {hi, lo}, 64'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("rstmid_nocommit", {31'd0, busy, hi, lo}, 64'(0));

    issue(MDU_MTHI, 32'h1234, '0);
    chk("mthi2_hi", 64'(hi), 64'h1234);
    chk("mthi2_busy", 64'(busy), 64'(0));
    run_op("b2b", MDU_MULTU, 32'd6, 32'd7, 5,
           32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
